// File: rtl/spi_command_framer.sv
// Frames the SPI byte stream into one op-code plus a counted operand strobe per chip-select frame.
// Optional frame idle timeout is built when SPI_FRAMER_TIMEOUT_EN is defined.
module spi_command_framer #(
  parameter int unsigned OPERAND_COUNT_WIDTH = 32,
  parameter int unsigned MAX_OPERANDS        = 4096,
  parameter int unsigned TIMEOUT_CYCLES      = 65535
) (
  input  logic                           spi_clock_in,
  input  logic                           spi_reset_n_in,
  input  logic                           cs_active_in,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid_in,
  output logic [7:0]                     op_code_out,
  output logic                           op_code_valid_out,
  output logic [7:0]                     operand_out,
  output logic                           operand_valid_out,
  output logic [OPERAND_COUNT_WIDTH-1:0] operand_count_out,
  output logic                           overflow_out,
`ifdef SPI_FRAMER_TIMEOUT_EN
  output logic                           timeout_out,
`endif
  output logic                           frame_done_out
);

  typedef enum logic [1:0] {StWaitCsIdle, StIdle, StOpcode, StOperands} state_e;

  localparam logic [OPERAND_COUNT_WIDTH-1:0] MaxCount = OPERAND_COUNT_WIDTH'(MAX_OPERANDS);

  state_e state;
  logic   byte_accept;

  assign byte_accept = byte_valid_in && cs_active_in;

`ifdef SPI_FRAMER_TIMEOUT_EN
  localparam int unsigned          IdleWidth = $clog2(TIMEOUT_CYCLES + 1);
  // The idle cycle that makes the run TIMEOUT_CYCLES long closes the frame.
  localparam logic [IdleWidth-1:0] IdleLimit = IdleWidth'(TIMEOUT_CYCLES - 1);

  logic [IdleWidth-1:0] idle_count;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge spi_clock_in) begin
    if (!spi_reset_n_in) begin
      state             <= StWaitCsIdle;
      op_code_out       <= 8'h00;
      op_code_valid_out <= 1'b0;
      operand_out       <= 8'h00;
      operand_valid_out <= 1'b0;
      operand_count_out <= '0;
      overflow_out      <= 1'b0;
      frame_done_out    <= 1'b0;
`ifdef SPI_FRAMER_TIMEOUT_EN
      timeout_out       <= 1'b0;
      idle_count        <= '0;
`endif
    end else begin
      operand_valid_out <= 1'b0;
      frame_done_out    <= 1'b0;
      case (state)
        // A reset can land mid-frame; wait for cs to drop so no stray byte becomes an op-code.
        StWaitCsIdle: begin
          if (!cs_active_in) state <= StIdle;
        end
        StIdle: begin
          if (cs_active_in) begin
            state        <= StOpcode;
            overflow_out <= 1'b0;
`ifdef SPI_FRAMER_TIMEOUT_EN
            timeout_out  <= 1'b0;
            idle_count   <= '0;
`endif
          end
        end
        StOpcode, StOperands: begin
          if (!cs_active_in) begin
            state             <= StIdle;
            op_code_valid_out <= 1'b0;
            operand_count_out <= '0;
            frame_done_out    <= 1'b1;
          end else if (byte_accept) begin
`ifdef SPI_FRAMER_TIMEOUT_EN
            idle_count <= '0;
`endif
            if (state == StOpcode) begin
              state             <= StOperands;
              op_code_out       <= byte_in;
              op_code_valid_out <= 1'b1;
            end else if (operand_count_out < MaxCount) begin
              operand_out       <= byte_in;
              operand_valid_out <= 1'b1;
              operand_count_out <= operand_count_out + OPERAND_COUNT_WIDTH'(1);
            end else begin
              overflow_out <= 1'b1;
            end
`ifdef SPI_FRAMER_TIMEOUT_EN
          end else if (idle_count == IdleLimit) begin
            state             <= StWaitCsIdle;
            op_code_valid_out <= 1'b0;
            operand_count_out <= '0;
            frame_done_out    <= 1'b1;
            timeout_out       <= 1'b1;
          end else begin
            idle_count <= idle_count + IdleWidth'(1);
`endif
          end
        end
        default: state <= StWaitCsIdle;
      endcase
    end
  end

endmodule
